riego_sched: RTL and testbench

RIEGO_SCHED -- requirements
Module: riego_sched

---
 rtl/riego_pkg.sv | 27 ++
 rtl/riego_timer.sv | 24 ++
 rtl/riego_sched.sv | 141 ++++++++++++++
 tb/tb_riego_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riego_pkg.sv
// Shared types and encodings for the irrigation pump scheduler.
package riego_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT1,
    GRANT2,
    PAUSA,
    FAULT
  } state_t;

  localparam logic [1:0] VALVE_STOP = 2'b00;
  localparam logic [1:0] VALVE_AGUA = 2'b11;

  localparam logic [1:0] ERR_NE    = 2'b00;
  localparam logic [1:0] ERR_ERROR = 2'b11;

  localparam logic [1:0] TURNO_NONE = 2'b00;
  localparam logic [1:0] TURNO_Z1   = 2'b01;
  localparam logic [1:0] TURNO_Z2   = 2'b10;

  // Timer reload value for a phase lasting t cycles (t in 1..256).
  function automatic logic [7:0] timer_load(input int t);
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/riego_timer.sv
// Slot/pause down-counter: loads a value, counts to zero and holds there.
module riego_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign done = (r_cnt == 8'd0);

endmodule

// File: rtl/riego_sched.sv
// Two-zone shared-pump irrigation scheduler with fault lockout.
// Optional slot counters CNT1/CNT2 exist only when RIEGO_STATS_EN is defined.
module riego_sched #(
  parameter int T_RIEGO = 16,
  parameter int T_PAUSA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] G1,
  input  logic [1:0] G2,
  input  logic [1:0] N,
  output logic [1:0] R1,
  output logic [1:0] R2,
  output logic [1:0] E,
  output logic [1:0] TURNO
`ifdef RIEGO_STATS_EN
  ,
  output logic [7:0] CNT1,
  output logic [7:0] CNT2
`endif
);

  import riego_pkg::*;

  localparam logic [7:0] LD_RIEGO = timer_load(T_RIEGO);
  localparam logic [7:0] LD_PAUSA = timer_load(T_PAUSA);

  state_t     r_state;
  state_t     w_next;
  state_t     w_arb;
  logic [1:0] r_code;
  logic [1:0] r_last;
  logic       w_fault;
  logic       w_req1;
  logic       w_req2;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_done;
  logic       w_end1;
  logic       w_end2;

  assign w_fault = (N != 2'b00);
  assign w_req1  = (G1 != 2'b00);
  assign w_req2  = (G2 != 2'b00);

  // Ties go to the zone that was not served last.
  always_comb begin
    w_arb = IDLE;
    if (w_req1 && w_req2) begin
      w_arb = (r_last == TURNO_Z1) ? GRANT2 : GRANT1;
    end else if (w_req1) begin
      w_arb = GRANT1;
    end else if (w_req2) begin
      w_arb = GRANT2;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_fault) begin
      w_next = FAULT;
    end else begin
      case (r_state)
        IDLE:    w_next = w_arb;
        GRANT1:  if (!w_req1 || w_done) w_next = PAUSA;
        GRANT2:  if (!w_req2 || w_done) w_next = PAUSA;
        // Pause expiry arbitrates like IDLE so a pending zone follows with no dead cycle.
        PAUSA:   if (w_done) w_next = w_arb;
        FAULT:   w_next = PAUSA;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = 8'd0;
    if (w_next == GRANT1 || w_next == GRANT2) begin
      w_load_val = LD_RIEGO;
    end else if (w_next == PAUSA) begin
      w_load_val = LD_PAUSA;
    end
  end

  assign w_end1 = (r_state == GRANT1) && (w_next == PAUSA);
  assign w_end2 = (r_state == GRANT2) && (w_next == PAUSA);

  riego_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .value (w_load_val),
    .done  (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_code  <= VALVE_STOP;
      r_last  <= TURNO_Z2;
    end else begin
      r_state <= w_next;
      if (w_next == GRANT1 && r_state != GRANT1) begin
        r_code <= G1;
      end else if (w_next == GRANT2 && r_state != GRANT2) begin
        r_code <= G2;
      end
      if (w_end1) begin
        r_last <= TURNO_Z1;
      end else if (w_end2) begin
        r_last <= TURNO_Z2;
      end
    end
  end

  // Outputs decode straight from state so reset closes the valves asynchronously.
  assign R1    = (r_state == GRANT1) ? r_code : VALVE_STOP;
  assign R2    = (r_state == GRANT2) ? r_code : VALVE_STOP;
  assign E     = (r_state == FAULT) ? ERR_ERROR : ERR_NE;
  assign TURNO = (r_state == GRANT1) ? TURNO_Z1 :
                 (r_state == GRANT2) ? TURNO_Z2 : TURNO_NONE;

`ifdef RIEGO_STATS_EN
  logic [7:0] r_cnt1;
  logic [7:0] r_cnt2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt1 <= 8'd0;
      r_cnt2 <= 8'd0;
    end else begin
      if (w_end1 && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
      if (w_end2 && r_cnt2 != 8'hFF) r_cnt2 <= r_cnt2 + 8'd1;
    end
  end

  assign CNT1 = r_cnt1;
  assign CNT2 = r_cnt2;
`endif

endmodule

// File: tb/tb_riego_sched.sv
// Directed self-checking bench for riego_sched with default timing (16 on, 2 pause).
module tb_riego_sched;

  logic       clk;
  logic       reset;
  logic [1:0] G1, G2, N;
  logic [1:0] R1, R2, E, TURNO;
`ifdef RIEGO_STATS_EN
  logic [7:0] CNT1, CNT2;
`endif

  int checks   = 0;
  int failures = 0;

  riego_sched dut (
    .clk   (clk),
    .reset (reset),
    .G1    (G1),
    .G2    (G2),
    .N     (N),
    .R1    (R1),
    .R2    (R2),
    .E     (E),
    .TURNO (TURNO)
`ifdef RIEGO_STATS_EN
    ,
    .CNT1  (CNT1),
    .CNT2  (CNT2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shared pump: both valves open at once is never legal.
  always @(negedge clk) begin
    if (!reset) chk("mutex", {7'd0, (R1 != 2'b00) && (R2 != 2'b00)}, 8'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; G1 = 2'b00; G2 = 2'b00; N = 2'b00;
    #2;
    chk("rst_R1", {6'd0, R1}, 8'd0);
    chk("rst_R2", {6'd0, R2}, 8'd0);
    chk("rst_E", {6'd0, E}, 8'd0);
    chk("rst_TURNO", {6'd0, TURNO}, 8'd0);
    tick(); tick();
    reset = 1'b0;

    // Single zone-1 request: 16 on, 2 off, on again.
    G1 = 2'b01;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("a_R1_on", {6'd0, R1}, 8'h01);
      chk("a_TURNO", {6'd0, TURNO}, 8'h01);
      tick();
    end
    chk("a_pause0", {6'd0, R1}, 8'd0);
    chk("a_pause0_T", {6'd0, TURNO}, 8'd0);
    tick();
    chk("a_pause1", {6'd0, R1}, 8'd0);
    tick();
    chk("a_regrant", {6'd0, R1}, 8'h01);
    // Early release by dropping the request.
    G1 = 2'b00;
    tick();
    chk("a_early_R1", {6'd0, R1}, 8'd0);
    tick(); tick();
    chk("a_idle_R1", {6'd0, R1}, 8'd0);
    chk("a_idle_T", {6'd0, TURNO}, 8'd0);

    // Fresh reset, both zones requesting: zone 1 first, then alternate.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    G1 = 2'b11; G2 = 2'b10;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("b_z1_R1", {6'd0, R1}, 8'h03);
      chk("b_z1_R2", {6'd0, R2}, 8'd0);
      tick();
    end
    chk("b_pause_a", {4'd0, R1, R2}, 8'd0);
    tick();
    chk("b_pause_b", {4'd0, R1, R2}, 8'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("b_z2_R2", {6'd0, R2}, 8'h02);
      chk("b_z2_T", {6'd0, TURNO}, 8'h02);
      tick();
    end
    chk("b_pause_c", {4'd0, R1, R2}, 8'd0);
    tick(); tick();
    chk("b_z1_again", {6'd0, R1}, 8'h03);
    // Nonzero change mid-slot must not alter the latched code.
    G1 = 2'b01;
    tick(); tick(); tick();
    chk("b_latched", {6'd0, R1}, 8'h03);
    // Reset mid-slot closes the valve before any clock edge.
    reset = 1'b1;
    #1;
    chk("b_async_R1", {6'd0, R1}, 8'd0);
    chk("b_async_T", {6'd0, TURNO}, 8'd0);
    G1 = 2'b00; G2 = 2'b00;
    tick();
    reset = 1'b0;

    // Zone 2 releases at slot cycle 5; held zone 1 follows the pause.
    G2 = 2'b01;
    tick();
    G1 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("c_R2_on", {6'd0, R2}, 8'h01);
      tick();
    end
    G2 = 2'b00;
    tick();
    chk("c_early_R2", {6'd0, R2}, 8'd0);
    chk("c_early_R1", {6'd0, R1}, 8'd0);
    tick();
    chk("c_pause_R1", {6'd0, R1}, 8'd0);
    tick();
    chk("c_z1_R1", {6'd0, R1}, 8'h01);
    chk("c_z1_T", {6'd0, TURNO}, 8'h01);

    // Level fault mid zone-1 slot.
    G2 = 2'b10;
    tick(); tick(); tick();
    N = 2'b01;
    tick();
    chk("d_fault_R1", {6'd0, R1}, 8'd0);
    chk("d_fault_E", {6'd0, E}, 8'h03);
    chk("d_fault_T", {6'd0, TURNO}, 8'd0);
    tick();
    chk("d_hold_E", {6'd0, E}, 8'h03);
    N = 2'b00; G1 = 2'b00;
    tick();
    chk("d_clear_E", {6'd0, E}, 8'd0);
    chk("d_clear_R1", {6'd0, R1}, 8'd0);
    tick();
    chk("d_pause_R2", {6'd0, R2}, 8'd0);
    tick();
    chk("d_z2_R2", {6'd0, R2}, 8'h02);
    chk("d_z2_T", {6'd0, TURNO}, 8'h02);

    // Fault on the same edge the slot would expire.
    for (int i = 0; i < 15; i++) tick();
    chk("e_last_cycle", {6'd0, R2}, 8'h02);
    N = 2'b10;
    tick();
    chk("e_fault_E", {6'd0, E}, 8'h03);
    chk("e_fault_R2", {6'd0, R2}, 8'd0);
`ifdef RIEGO_STATS_EN
    chk("e_cnt2", CNT2, 8'd1);
    chk("e_cnt1", CNT1, 8'd0);
`endif
    // Zone 2 was last served (zone 1's aborted slot is not recorded): zone 1 wins the tie.
    N = 2'b00; G1 = 2'b01; G2 = 2'b10;
    tick();
    chk("e_pause_E", {6'd0, E}, 8'd0);
    tick(); tick();
    chk("e_tie_R1", {6'd0, R1}, 8'h01);
    chk("e_tie_R2", {6'd0, R2}, 8'd0);

`ifdef RIEGO_STATS_EN
    G2 = 2'b00;
    for (int i = 0; i < 300 * 18; i++) tick();
    chk("f_cnt1_sat", CNT1, 8'hFF);
    reset = 1'b1;
    #1;
    chk("f_cnt1_rst", CNT1, 8'd0);
    tick();
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
